// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, phase encoding and width default for the CPU sequencer
package cpu_pkg;
    localparam int OP_W_DEF = 3;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;
    // HALT_LD is HALTED after load_in has been seen high; both report phase 4
    typedef enum logic [3:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
        OP_ADDR, OP_FETCH, ALU_OP, STORE,
        HALTED, HALT_LD
    } phase_t;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control/status bundle between the sequencer (master) and the datapath (slave)
interface cpu_sequencer_if
    import cpu_pkg::*;
#(parameter int OP_W = OP_W_DEF);
    logic            load_in, zero, mem_ready;
    logic [OP_W-1:0] opcode;
    logic            sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err;
    logic [OP_W-1:0] alu_op;
    logic [2:0]      phase;
    modport master(
        input  load_in, opcode, zero, mem_ready,
        output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, alu_op, halt, bus_err, phase
    );
    modport slave(
        output load_in, opcode, zero, mem_ready,
        input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, alu_op, halt, bus_err, phase
    );
endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// seq_wait_timer: saturating count of held memory-wait cycles, flags when WAIT_MAX is reached
module seq_wait_timer #(parameter int WAIT_MAX = 15) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    output logic expired
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] MAX = CW'(WAIT_MAX);
    logic [CW-1:0] cnt;
    assign expired = cnt == MAX;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (hold && !expired) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer with memory wait states,
// bus-timeout halt and external program-load freeze
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W     = OP_W_DEF,
    parameter int WAIT_MAX = 15
) (
    input logic           clock,
    input logic           reset,
    cpu_sequencer_if.master bus
);
    phase_t          state, nxt;
    logic [OP_W-1:0] alu_q;
    logic            bus_err_q;
    logic            valid, hlt, skz, sto, jmp, aluop;
    logic            wait_st, held, hold, timeout, expired, halted, en;
    logic [2:0]      op3;

    assign op3   = alu_q[2:0];
    assign valid = (alu_q >> 3) == '0;
    assign hlt   = valid && op3 == OP_HLT;
    assign skz   = valid && op3 == OP_SKZ;
    assign sto   = valid && op3 == OP_STO;
    assign jmp   = valid && op3 == OP_JMP;
    assign aluop = valid && (op3 == OP_ADD || op3 == OP_AND || op3 == OP_XOR || op3 == OP_LDA);
    assign en    = !bus.load_in;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clock(clock), .reset(reset), .hold(hold), .expired(expired)
    );

    always_comb begin
        halted  = state == HALTED || state == HALT_LD;
        wait_st = state == INST_FETCH || (state == OP_FETCH && aluop) || (state == STORE && sto);
        held    = wait_st && !bus.mem_ready && en;
        timeout = held && expired;
        hold    = held && !expired;
        nxt = !en                         ? (halted ? HALT_LD : INST_ADDR)
            : state == HALTED             ? HALTED
            : state == HALT_LD            ? INST_ADDR
            : timeout                     ? HALTED
            : held                        ? state
            : (state == OP_ADDR && hlt)   ? HALTED
            : state == STORE              ? INST_ADDR
            : phase_t'(state + 4'd1);
    end

    always_comb begin
        bus.sel     = state inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
        bus.rd      = en && (state inside {INST_FETCH, INST_LOAD, IDLE}
                      || (aluop && state inside {OP_FETCH, ALU_OP, STORE}));
        bus.wr      = en && state == STORE && sto;
        bus.ld_ir   = en && state == INST_LOAD;
        bus.ld_ac   = en && state == STORE && aluop;
        bus.ld_pc   = en && state == STORE && jmp;
        bus.inc_pc  = en && ((state == OP_ADDR && valid && !hlt) || (state == STORE && skz && bus.zero));
        bus.data_e  = en && sto && state inside {ALU_OP, STORE};
        bus.alu_op  = alu_q;
        bus.halt    = halted;
        bus.bus_err = bus_err_q;
        bus.phase   = halted ? 3'd4 : 3'(state);
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= INST_ADDR;
            alu_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == INST_LOAD && bus.mem_ready && en) alu_q <= bus.opcode;
            if (timeout) bus_err_q <= 1'b1;
        end
endmodule
